// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_ctrl
// Start-edge hunt, mid-bit rx_tick generation, FWFT byte FIFO and rx status.
// Rev    : 1.0
// ============================================================================
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FRAME_TICKS  = 11,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              rx_line,
  output logic              rx_tick,
  output logic              rx_enable,
  input  logic              rx_valid_in,
  input  logic [7:0]        rx_data_in,
  input  logic              rx_err_in,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overrun,
  output logic [7:0]        err_count,
  input  logic              clr_status,
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int TCK_W = $clog2(FRAME_TICKS + 1);
  localparam int OCC_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0] c_half  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] c_full  = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
  localparam logic [TCK_W-1:0] c_last  = TCK_W'(FRAME_TICKS - 1);
  localparam logic [OCC_W-1:0] c_depth = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_HUNT  = 2'd1,
    ST_FRAME = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_sync1;
  logic r_sync2;
  logic r_sync_d;
  logic w_start_edge;

  logic [CNT_W-1:0] r_tick_cnt;
  logic [TCK_W-1:0] r_tick_num;
  logic w_tick;
  logic w_last_tick;

  logic r_rx_enable;
  logic r_busy;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0]  r_count;
  logic w_full;
  logic w_empty;
  logic w_rd;
  logic w_wr;
  logic w_drop;

  logic       r_overrun;
  logic [7:0] r_err_count;

  // r_sync_d holds the previous synchronised sample for falling-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= rx_line;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_start_edge = r_sync_d & ~r_sync2;

  assign w_tick      = (r_state == ST_FRAME) && (r_tick_cnt == c_one);
  assign w_last_tick = w_tick && (r_tick_num == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFF:   if (enable)       w_state_nxt = ST_HUNT;
      ST_HUNT:  if (w_start_edge) w_state_nxt = ST_FRAME;
      ST_FRAME: if (w_last_tick)  w_state_nxt = ST_HUNT;
      default:                    w_state_nxt = ST_OFF;
    endcase
    if (!enable) begin
      w_state_nxt = ST_OFF;
    end
  end

  // Half-bit preload centres every subsequent tick in its bit cell
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_tick_num <= '0;
    end else if (!enable || r_state == ST_OFF) begin
      r_tick_cnt <= '0;
      r_tick_num <= '0;
    end else if (r_state == ST_HUNT) begin
      r_tick_cnt <= w_start_edge ? c_half : '0;
      r_tick_num <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= c_full;
      r_tick_num <= r_tick_num + TCK_W'(1);
    end else begin
      r_tick_cnt <= r_tick_cnt - c_one;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_enable <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_enable <= (w_state_nxt != ST_OFF);
      r_busy      <= (w_state_nxt == ST_FRAME);
    end
  end

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);
  assign w_rd    = !w_empty && m_ready;
  assign w_wr    = rx_valid_in && (!w_full || w_rd);
  assign w_drop  = rx_valid_in && w_full && !w_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= rx_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear wins over stored state, but a same-cycle event still lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun   <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (clr_status) begin
        r_overrun <= w_drop;
      end else if (w_drop) begin
        r_overrun <= 1'b1;
      end

      if (clr_status) begin
        r_err_count <= {7'd0, rx_err_in};
      end else if (rx_err_in && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign rx_tick    = w_tick;
  assign rx_enable  = r_rx_enable;
  assign busy       = r_busy;
  assign m_data     = r_mem[r_rd_ptr];
  assign m_valid    = !w_empty;
  assign fifo_count = r_count;
  assign overrun    = r_overrun;
  assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_ctrl
// Self-checking bench: vector table, random FIFO/status model, tick timing.
// Rev    : 1.0
// ============================================================================
module tb_uart_rx_ctrl;

  localparam int CPB   = 868;
  localparam int HALF  = CPB / 2;
  localparam int NTICK = 11;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst, enable, rx_line, rx_tick, rx_enable;
  logic rx_valid_in, rx_err_in, m_valid, m_ready, overrun, clr_status, busy;
  logic [7:0]  rx_data_in, m_data, err_count;
  logic [AW:0] fifo_count;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int tick_q[$];

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .FRAME_TICKS (NTICK),
    .FIFO_DEPTH  (DEPTH),
    .ADDR_W      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .rx_line    (rx_line),
    .rx_tick    (rx_tick),
    .rx_enable  (rx_enable),
    .rx_valid_in(rx_valid_in),
    .rx_data_in (rx_data_in),
    .rx_err_in  (rx_err_in),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fifo_count (fifo_count),
    .overrun    (overrun),
    .err_count  (err_count),
    .clr_status (clr_status),
    .busy       (busy)
  );

  typedef struct {
    string      name;
    bit         v;
    logic [7:0] d;
    bit         rdy;
    bit         err;
    bit         clr;
    bit         ev;
    logic [7:0] ed;
    bit         chk_d;
    int         ecnt;
    bit         eov;
    int         eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (rx_tick === 1'b1) tick_q.push_back(cyc);
  endtask

  task automatic run_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic void add(input string n, input bit v, input int d, input bit rdy,
                              input bit err, input bit clr, input bit ev, input int ed,
                              input bit chk_d, input int ecnt, input bit eov, input int eerr);
    vec_t t;
    t.name = n; t.v = v; t.d = 8'(d); t.rdy = rdy; t.err = err; t.clr = clr;
    t.ev = ev; t.ed = 8'(ed); t.chk_d = chk_d; t.ecnt = ecnt; t.eov = eov; t.eerr = eerr;
    tbl.push_back(t);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Random-phase reference model state
  byte unsigned mq[$];
  bit         m_ov;
  int         m_err;
  bit         rv, rr, re, rc, rd_ok, drop;
  logic [7:0] rdat;
  int         c, last, fifth;
  int         drain_heads[7] = '{8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h19, 8'h1A};

  initial begin
    // Vector table: starts from an empty FIFO with cleared status
    add("wr_a5",   1, 'hA5, 0, 0, 0, 1, 'hA5, 1, 1, 0, 0);
    add("wr_3c",   1, 'h3C, 0, 0, 0, 1, 'hA5, 1, 2, 0, 0);
    add("rd_a5",   0, 0,    1, 0, 0, 1, 'h3C, 1, 1, 0, 0);
    add("rd_3c",   0, 0,    1, 0, 0, 0, 0,    0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      add($sformatf("fill%0d", i), 1, 'h10 + i, 0, 0, 0, 1, 'h10, 1, i + 1, 0, 0);
    add("ovf_drop", 1, 'h18, 0, 0, 0, 1, 'h10, 1, 8, 1, 0);
    add("full_rw",  1, 'h19, 1, 0, 0, 1, 'h11, 1, 8, 1, 0);
    add("clr_ov",   0, 0,    0, 0, 1, 1, 'h11, 1, 8, 0, 0);
    add("full_rw2", 1, 'h1A, 1, 0, 0, 1, 'h12, 1, 8, 0, 0);
    add("err1",     0, 0,    0, 1, 0, 1, 'h12, 1, 8, 0, 1);
    add("err2",     0, 0,    0, 1, 0, 1, 'h12, 1, 8, 0, 2);
    add("clr_err",  0, 0,    0, 1, 1, 1, 'h12, 1, 8, 0, 1);
    add("clr_all",  0, 0,    0, 0, 1, 1, 'h12, 1, 8, 0, 0);
    add("ovf_clr",  1, 'h1B, 0, 0, 1, 1, 'h12, 1, 8, 1, 0);
    add("clr_ov2",  0, 0,    0, 0, 1, 1, 'h12, 1, 8, 0, 0);
    for (int i = 0; i < 7; i++)
      add($sformatf("drain%0d", i), 0, 0, 1, 0, 0, 1, drain_heads[i], 1, 7 - i, 0, 0);
    add("drain_last", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset
    rst = 1'b1; enable = 1'b0; rx_line = 1'b1; rx_valid_in = 1'b0; rx_data_in = '0;
    rx_err_in = 1'b0; m_ready = 1'b0; clr_status = 1'b0;
    repeat (3) step();
    check("rst_tick", rx_tick, 0);
    check("rst_rx_enable", rx_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overrun", overrun, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b0;
    step();

    // Idle hunt with line high
    enable = 1'b1;
    step();
    tick_q.delete();
    repeat (1000) step();
    check("idle_ticks", tick_q.size(), 0);
    check("idle_rx_enable", rx_enable, 1);
    check("idle_busy", busy, 0);
    check("idle_m_valid", m_valid, 0);
    check("idle_count", fifo_count, 0);

    // Randomised FIFO / status traffic against the queue model
    mq.delete(); m_ov = 1'b0; m_err = 0;
    for (int i = 0; i < 600; i++) begin
      rv = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) == 0);
      re = 1'($urandom_range(0, 1));
      rc = ($urandom_range(0, 49) == 0);
      rdat = 8'($urandom);
      rx_valid_in = rv; rx_data_in = rdat; m_ready = rr; rx_err_in = re; clr_status = rc;
      rd_ok = (mq.size() != 0) && rr;
      drop  = rv && (mq.size() == DEPTH) && !rd_ok;
      if (rd_ok) void'(mq.pop_front());
      if (rv && !drop) mq.push_back(rdat);
      m_ov  = rc ? drop : (m_ov | drop);
      m_err = rc ? int'(re) : ((m_err + int'(re) > 255) ? 255 : m_err + int'(re));
      step();
      vectors++;
      if (m_valid !== (mq.size() != 0) || int'(fifo_count) != mq.size() ||
          (mq.size() != 0 && m_data !== mq[0]) || overrun !== m_ov || int'(err_count) != m_err) begin
        miscompares++;
        $display("FAIL rand%0d: got v=%0b cnt=%0d d=%0h ov=%0b err=%0d, expected v=%0b cnt=%0d d=%0h ov=%0b err=%0d",
                 i, m_valid, fifo_count, m_data, overrun, err_count, (mq.size() != 0), mq.size(),
                 (mq.size() != 0) ? mq[0] : 8'h00, m_ov, m_err);
      end
    end
    rx_valid_in = 1'b0; rx_err_in = 1'b0; m_ready = 1'b1; clr_status = 1'b0;
    repeat (DEPTH + 2) step();
    m_ready = 1'b0; clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    check("drained_count", fifo_count, 0);
    check("drained_overrun", overrun, 0);
    check("drained_err", err_count, 0);

    // Table-driven FIFO and status vectors
    foreach (tbl[k]) begin
      rx_valid_in = tbl[k].v; rx_data_in = tbl[k].d; m_ready = tbl[k].rdy;
      rx_err_in = tbl[k].err; clr_status = tbl[k].clr;
      step();
      vectors++;
      if (m_valid !== tbl[k].ev || int'(fifo_count) != tbl[k].ecnt ||
          (tbl[k].chk_d && m_data !== tbl[k].ed) || overrun !== tbl[k].eov ||
          int'(err_count) != tbl[k].eerr) begin
        miscompares++;
        $display("FAIL %s: got v=%0b cnt=%0d d=%0h ov=%0b err=%0d, expected v=%0b cnt=%0d d=%0h ov=%0b err=%0d",
                 tbl[k].name, m_valid, fifo_count, m_data, overrun, err_count,
                 tbl[k].ev, tbl[k].ecnt, tbl[k].ed, tbl[k].eov, tbl[k].eerr);
      end
    end
    rx_valid_in = 1'b0; m_ready = 1'b0; rx_err_in = 1'b0; clr_status = 1'b0;

    // Error counter saturation
    rx_err_in = 1'b1;
    repeat (254) step();
    check("err_254", err_count, 254);
    repeat (46) step();
    check("err_sat", err_count, 255);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0; rx_err_in = 1'b0;
    check("err_clr_event", err_count, 1);

    // Full frame, with a line fall landing on the final tick that must be ignored
    tick_q.delete();
    c = cyc;
    rx_line = 1'b0;
    run_until(c + 3);
    check("busy_start", busy, 1);
    run_until(c + CPB);
    rx_line = 1'b1;
    last = c + 2 + HALF + (NTICK - 1) * CPB;
    run_until(last - 2);
    rx_line = 1'b0;
    run_until(last);
    check("tick_last", rx_tick, 1);
    check("busy_last", busy, 1);
    run_until(last + 1);
    check("busy_end", busy, 0);
    check("hunt_rx_enable", rx_enable, 1);
    run_until(last + 1000);
    rx_line = 1'b1;
    run_until(last + 2000);
    check("frame_tick_count", tick_q.size(), NTICK);
    for (int k = 0; k < NTICK; k++) begin
      if (k < tick_q.size()) check($sformatf("tick%0d_cycle", k), tick_q[k], c + 2 + HALF + k * CPB);
      else check($sformatf("tick%0d_missing", k), -1, c + 2 + HALF + k * CPB);
    end

    // Disable mid-frame at the 5th tick; FIFO contents must survive
    rx_valid_in = 1'b1; rx_data_in = 8'h5A;
    step();
    rx_valid_in = 1'b0;
    tick_q.delete();
    c = cyc;
    rx_line = 1'b0;
    run_until(c + CPB);
    rx_line = 1'b1;
    fifth = c + 2 + HALF + 4 * CPB;
    run_until(fifth);
    check("tick5", rx_tick, 1);
    enable = 1'b0;
    step();
    check("off_rx_enable", rx_enable, 0);
    check("off_busy", busy, 0);
    run_until(cyc + 2 * CPB);
    check("off_tick_count", tick_q.size(), 5);
    check("off_fifo_count", fifo_count, 1);
    check("off_fifo_data", m_data, 8'h5A);

    enable = 1'b1;
    step();
    check("reen_rx_enable", rx_enable, 1);
    repeat (10) step();
    tick_q.delete();
    c = cyc;
    rx_line = 1'b0;
    run_until(c + 3);
    check("reen_busy", busy, 1);
    run_until(c + 2 + HALF + 1);
    check("reen_tick_count", tick_q.size(), 1);
    if (tick_q.size() > 0) check("reen_tick_cycle", tick_q[0], c + 2 + HALF);
    else check("reen_tick_missing", -1, c + 2 + HALF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Sequencing controller for the UART byte receiver. Detects start-bit edges on the serial line, generates the mid-bit-aligned sample strobe (rx_tick) and enable that drive the receiver, and buffers received bytes in a small FIFO with a valid/ready output. It also keeps sticky overrun and saturating error statistics. Sits between the pin-side receiver and the consumer logic (loopback, LED/status, command parser).

Parameters:
CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); must be >= 4
FRAME_TICKS, 11, rx_tick pulses per frame (start + 8 data + parity + stop)
FIFO_DEPTH, 8, byte buffer entries; power of two, >= 2
ADDR_W, 3, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  controller enable; 0 forces OFF state
rx_line  in  1  raw serial line, asynchronous, idle high
rx_tick  out  1  one-clk sample strobe to receiver, mid-bit
rx_enable  out  1  receiver enable, 1 whenever state != OFF
rx_valid_in  in  1  one-clk pulse from receiver: byte complete
rx_data_in  in  8  received byte, qualified by rx_valid_in
rx_err_in  in  1  one-clk pulse from receiver: parity/stop error
m_data  out  8  FIFO head byte
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data when m_valid & m_ready
fifo_count  out  ADDR_W+1  current occupancy, 0..FIFO_DEPTH
overrun  out  1  sticky: byte dropped because FIFO was full
err_count  out  8  saturating count of rx_err_in pulses
clr_status  in  1  one-clk pulse: clears overrun and err_count
busy  out  1  1 while state == FRAME

Behaviour:
- Reset (async, rst=1): state OFF; sync flops = 1; bit counter = 0; tick counter = 0; FIFO empty; all outputs 0 (m_data = 0, fifo_count = 0, err_count = 0).
- rx_line passes through a 2-flop synchroniser (reset value 1). Start edge = synced value 1 in previous cycle, 0 in current cycle.
- State OFF:
  - rx_tick = 0; counters held at 0.
  - enable=1 -> HUNT next cycle.
- State HUNT:
  - Tick counter idle.
  - Start edge -> FRAME; tick counter loaded with CLKS_PER_BIT/2 (integer division); tick count = 0.
- State FRAME:
  - Tick counter decrements each clk. At 1 it asserts rx_tick for one cycle, reloads CLKS_PER_BIT, and increments tick count.
  - First rx_tick occurs CLKS_PER_BIT/2 cycles after the edge cycle; subsequent ticks follow every CLKS_PER_BIT cycles.
  - On the tick that brings the tick count to FRAME_TICKS -> HUNT. An edge in that same cycle is ignored; a new frame needs a fresh 1->0 edge.
- enable=0 in any state -> OFF next cycle. A partial frame is abandoned and no further ticks are issued. FIFO contents and status are retained.
- FIFO (first-word fall-through):
  - m_valid = (count != 0); m_data = entry at read pointer. Pointers wrap modulo FIFO_DEPTH.
  - Write on rx_valid_in; read on m_valid & m_ready.
  - Full, write only: byte dropped, overrun set, count unchanged.
  - Full, simultaneous read and write: both occur, count unchanged, no overrun.
  - Empty, simultaneous write (m_valid=0): write only, m_valid rises next cycle. Write-to-m_valid latency is 1 clk.
  - rx_valid_in is accepted in any state, including OFF.
- Status:
  - err_count increments on rx_err_in and saturates at 255.
  - clr_status has priority over stored values, but an event in the same cycle still registers: result is overrun = 1 and/or err_count = 1.
- rx_enable and busy are registered decodes of state.

Test Plan:
- Reset release, enable=1, line held high 1000 clks -> state HUNT, rx_tick never pulses, m_valid=0, fifo_count=0.
- Line falls at cycle T (after sync) -> rx_tick pulses at T+434, T+1302, ... (11 pulses); busy drops after the 11th; line high afterwards -> no further ticks.
- Inject rx_valid_in with 0xA5, 0x3C, m_ready=0 -> fifo_count=2, m_data=0xA5; m_ready=1 for 2 clks -> 0xA5 then 0x3C delivered, m_valid=0.
- 9 writes with m_ready=0 -> fifo_count=8, overrun=1, head=first byte. Next cycle, write with m_ready=1 -> count stays 8, overrun not re-triggered.
- 300 rx_err_in pulses -> err_count=255. clr_status coinciding with an error pulse -> err_count=1.
- enable=0 at 5th tick of a frame -> OFF next clk, no more ticks, FIFO intact. enable=1 -> HUNT, next edge restarts at half-bit offset.
